// File: rtl/accel_pkg.sv
// Shared constants for the accel_seq_alu peripheral: opcodes, register
// map, STATUS bit positions, FSM states and small opcode helpers.
package accel_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_MUL = 4'd6;
  localparam logic [3:0] OP_MAD = 4'd7;
  localparam logic [3:0] OP_MAC = 4'd8;

  localparam logic [3:0] ADDR_A_LO   = 4'h0;
  localparam logic [3:0] ADDR_A_HI   = 4'h1;
  localparam logic [3:0] ADDR_B_LO   = 4'h2;
  localparam logic [3:0] ADDR_B_HI   = 4'h3;
  localparam logic [3:0] ADDR_C_LO   = 4'h4;
  localparam logic [3:0] ADDR_C_HI   = 4'h5;
  localparam logic [3:0] ADDR_OP     = 4'h6;
  localparam logic [3:0] ADDR_STATUS = 4'h7;
  localparam logic [3:0] ADDR_R0     = 4'h8;
  localparam logic [3:0] ADDR_R1     = 4'h9;
  localparam logic [3:0] ADDR_R2     = 4'hA;
  localparam logic [3:0] ADDR_R3     = 4'hB;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MULT = 2'd2
  } state_e;

  function automatic logic op_reserved(input logic [3:0] op);
    return op > OP_MAC;
  endfunction

  function automatic logic op_is_mul(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MAD) || (op == OP_MAC);
  endfunction

endpackage

// File: rtl/accel_seq_alu_mul.sv
// Shift-add unsigned multiplier: result = a*b + addend, DATA_W steps.
// Ports: clk, rst_n, start, a, b, addend in; busy, done, result out.
// done/result are combinational in the last step cycle so the caller
// can capture the product on the same edge that ends the operation.
module accel_seq_mul #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  input  logic [2*DATA_W-1:0]   addend,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   result
);

  localparam int RES_W = 2 * DATA_W;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic [RES_W-1:0]  mcand;
  logic [RES_W-1:0]  acc;
  logic [RES_W-1:0]  add_q;
  logic [RES_W-1:0]  acc_nxt;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;
  logic              busy_q;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign busy    = busy_q;
  assign done    = busy_q && (cnt == LAST);
  // Addend folds in with the final partial product.
  assign result  = acc_nxt + add_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      add_q  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      mcand  <= RES_W'(a);
      mplier <= b;
      acc    <= '0;
      add_q  <= addend;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/accel_seq_alu.sv
// Byte-bus ALU/multiplier peripheral: regs A/B/C/OP/STATUS/R, FSM.
// Ports: clk, rst_n, ui_in(unused), uo_out, address, data_write,
// data_in, data_out. Macro ACCEL_UO_STATUS_EN mirrors STATUS on uo_out.
module accel_seq_alu
  import accel_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int RES_W = 2 * DATA_W;
  localparam bit HI_EN = DATA_W > 8;

  state_e state_q, state_d;

  logic [15:0]       a_q, b_q, c_q;
  logic [3:0]        op_q;
  logic [RES_W-1:0]  r_q;
  logic              done_q, err_q;
  logic [DATA_W-1:0] wa, wb;
  logic [3:0]        wop;

  logic              busy;
  logic              op_wr, launch, err_set;
  logic              mul_start, mul_done, mul_busy;
  logic [RES_W-1:0]  addend, mul_res, alu_res;
  logic [DATA_W:0]   sum, dif;
  logic [31:0]       r_ext;
  logic              unused_ok;

  assign busy  = state_q != S_IDLE;
  assign op_wr = data_write && address == ADDR_OP && !busy;

  assign launch    = op_wr && !op_reserved(data_in[3:0]);
  assign mul_start = launch && op_is_mul(data_in[3:0]);

  assign err_set =
    (op_wr && op_reserved(data_in[3:0])) ||
    (busy && data_write &&
     (address <= ADDR_OP || address == ADDR_R0));

  always_comb begin
    addend = '0;
    if (data_in[3:0] == OP_MAD)
      addend = RES_W'(c_q[DATA_W-1:0]);
    else if (data_in[3:0] == OP_MAC)
      addend = r_q;
  end

  accel_seq_mul #(.DATA_W(DATA_W)) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mul_start),
    .a      (a_q[DATA_W-1:0]),
    .b      (b_q[DATA_W-1:0]),
    .addend (addend),
    .busy   (mul_busy),
    .done   (mul_done),
    .result (mul_res)
  );

  // Carry/borrow land in bit DATA_W of the widened sum/difference.
  assign sum = {1'b0, wa} + {1'b0, wb};
  assign dif = {1'b0, wa} - {1'b0, wb};

  always_comb begin
    alu_res = r_q;
    case (wop)
      OP_ADD:  alu_res = RES_W'(sum);
      OP_SUB:  alu_res = RES_W'(dif);
      OP_AND:  alu_res = RES_W'(wa & wb);
      OP_OR:   alu_res = RES_W'(wa | wb);
      OP_XOR:  alu_res = RES_W'(wa ^ wb);
      default: alu_res = r_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (launch)
        state_d = op_is_mul(data_in[3:0]) ? S_MULT : S_EXEC;
      S_EXEC: state_d = S_IDLE;
      S_MULT: if (mul_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
      op_q <= '0;
    end else if (data_write && !busy) begin
      case (address)
        ADDR_A_LO: a_q[7:0] <= data_in;
        ADDR_A_HI: if (HI_EN) a_q[15:8] <= data_in;
        ADDR_B_LO: b_q[7:0] <= data_in;
        ADDR_B_HI: if (HI_EN) b_q[15:8] <= data_in;
        ADDR_C_LO: c_q[7:0] <= data_in;
        ADDR_C_HI: if (HI_EN) c_q[15:8] <= data_in;
        ADDR_OP:   op_q <= data_in[3:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa  <= '0;
      wb  <= '0;
      wop <= '0;
    end else if (launch) begin
      wa  <= a_q[DATA_W-1:0];
      wb  <= b_q[DATA_W-1:0];
      wop <= data_in[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      done_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      r_q    <= alu_res;
      done_q <= 1'b1;
    end else if (state_q == S_MULT && mul_done) begin
      r_q    <= mul_res;
      done_q <= 1'b1;
    end else if (launch) begin
      done_q <= 1'b0;
    end else if (data_write && !busy &&
                 address == ADDR_R0) begin
      r_q    <= '0;
      done_q <= 1'b0;
    end
  end

  // A new error outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (err_set)
      err_q <= 1'b1;
    else if (data_write && address == ADDR_STATUS &&
             data_in[ST_ERR])
      err_q <= 1'b0;
  end

  assign r_ext = 32'(r_q);

  always_comb begin
    data_out = 8'h00;
    case (address)
      ADDR_A_LO:   data_out = a_q[7:0];
      ADDR_A_HI:   data_out = a_q[15:8];
      ADDR_B_LO:   data_out = b_q[7:0];
      ADDR_B_HI:   data_out = b_q[15:8];
      ADDR_C_LO:   data_out = c_q[7:0];
      ADDR_C_HI:   data_out = c_q[15:8];
      ADDR_OP:     data_out = {4'h0, op_q};
      ADDR_STATUS: data_out = {5'b0, err_q, done_q, busy};
      ADDR_R0:     data_out = r_ext[7:0];
      ADDR_R1:     data_out = r_ext[15:8];
      ADDR_R2:     data_out = r_ext[23:16];
      ADDR_R3:     data_out = r_ext[31:24];
      default:     data_out = 8'h00;
    endcase
  end

`ifdef ACCEL_UO_STATUS_EN
  // Bit 0 stays low: it is shared with UART TX.
  assign uo_out = {4'b0, err_q, done_q, busy, 1'b0};
`else
  assign uo_out = 8'h00;
`endif

  assign unused_ok = ^{1'b0, ui_in, mul_busy};

endmodule
